// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial-pattern detector.
//   seq_state_e : run-controller state encoding (idle / armed / done)
//   Def*        : default parameter values for seq_det_ctrl
//   len_mask()  : mask with the low 'len' bits set
package seq_det_pkg;

  localparam int unsigned DefPatW       = 5;
  localparam int unsigned DefCntW       = 8;
  localparam logic [4:0]  DefPattern    = 5'b11011;
  localparam int unsigned DefTimeoutCyc = 16;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StDone
  } seq_state_e;

  // Returns 32 bits; callers truncate to their pattern width.
  function automatic logic [31:0] len_mask(input int unsigned len);
    if (len >= 32) begin
      return '1;
    end
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/seq_det_core.sv
// Serial history shift register, fill counter and masked pattern compare.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clr            clear history and fill (start of a run)
//   en             sample 'in' this cycle
//   in             serial data bit
//   pattern, len   pattern to match; pattern[len-1] is the oldest bit
//   overlap        1 = keep fill on a match, 0 = matched bits are consumed
//   hit            combinational: the bit sampled this cycle completes a match
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = DefPatW,
  parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             hit
);

  logic [PAT_W-1:0] hist_q, hist_d, hist_shift, mask;
  logic [LEN_W-1:0] fill_q, fill_d, fill_inc;

  always_comb begin
    hist_d     = hist_q;
    fill_d     = fill_q;
    hit        = 1'b0;
    mask       = PAT_W'(len_mask(32'(len)));
    hist_shift = {hist_q[PAT_W-2:0], in};
    // Fill counts valid history bits, saturating at the register depth.
    fill_inc   = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = hist_shift;
      hit    = (fill_inc >= len) && ((hist_shift & mask) == (pattern & mask));
      fill_d = (hit && !overlap) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable Moore serial-pattern detector with run controller.
// Optional watchdog enabled by defining SEQ_DET_CTRL_TIMEOUT_EN.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in                        serial data bit, sampled while armed
//   cfg_valid / cfg_ready     configuration handshake (ready when not armed)
//   cfg_pattern, cfg_len      pattern and its length (legal 1..PAT_W)
//   cfg_overlap, cfg_limit    overlap mode, match limit (0 = unlimited)
//   cfg_err                   one-cycle pulse after a rejected config
//   start, abort              arm the detector / return to idle (abort wins)
//   out                       registered detect, one cycle per match
//   match_cnt                 matches in the current run
//   busy, done, timeout       armed, done, watchdog expired
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W       = DefPatW,
  parameter int unsigned      CNT_W       = DefCntW,
  parameter logic [PAT_W-1:0] DEF_PAT     = PAT_W'(DefPattern),
  parameter int unsigned      TIMEOUT_CYC = DefTimeoutCyc
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
  input  logic                         cfg_overlap,
  input  logic [CNT_W-1:0]             cfg_limit,
  output logic                         cfg_err,
  input  logic                         start,
  input  logic                         abort,
  output logic                         out,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout
);

  localparam int unsigned LEN_W = $clog2(PAT_W + 1);

  seq_state_e state_q, state_d;

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] lim_q;
  logic             cfg_err_q;
  logic             out_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  logic cfg_fire, cfg_legal;
  logic start_run, core_en, hit;
  logic limit_reached, wd_expire;

  assign cfg_fire  = cfg_valid && (state_q != StArmed);
  assign cfg_legal = (cfg_len != '0) && (32'(cfg_len) <= PAT_W);

  // A run starts from idle or done; abort in the same cycle suppresses it.
  assign start_run = start && !abort && (state_q != StArmed);
  assign core_en   = (state_q == StArmed) && !abort;

  seq_det_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_run),
    .en      (core_en),
    .in      (in),
    .pattern (pat_q),
    .len     (len_q),
    .overlap (ovl_q),
    .hit     (hit)
  );

  assign cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign limit_reached = hit && (lim_q != '0) && (cnt_inc == lim_q);

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;

  // Expires on the TIMEOUT_CYC-th consecutive armed cycle without a match.
  assign wd_expire = core_en && !hit && (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    if (start_run || hit || wd_expire) begin
      wd_d = '0;
    end else if (state_q == StArmed) begin
      wd_d = wd_q + 1'b1;
    end
    if (start_run || abort) begin
      timeout_d = 1'b0;
    end else if (wd_expire) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: if (start) state_d = StArmed;
        StArmed:        if (limit_reached || wd_expire) state_d = StDone;
        default:        state_d = StIdle;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    busy      = (state_q == StArmed);
    done      = (state_q == StDone);
    cfg_ready = (state_q != StArmed);
    out       = out_q;
    match_cnt = cnt_q;
    cfg_err   = cfg_err_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start_run) begin
      cnt_d = '0;
    end else if (hit) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= DEF_PAT;
      len_q     <= LEN_W'(PAT_W);
      ovl_q     <= 1'b1;
      lim_q     <= '0;
      cfg_err_q <= 1'b0;
      out_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      cfg_err_q <= cfg_fire && !cfg_legal;
      out_q     <= hit;
      cnt_q     <= cnt_d;
      // Illegal lengths complete the handshake but keep the old config.
      if (cfg_fire && cfg_legal) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        ovl_q <= cfg_overlap;
        lim_q <= cfg_limit;
      end
    end
  end

endmodule
